// File: rtl/adc_formatea_prom.sv
// ADC sample formatter: offset-binary to two's complement, optional 2^AVG_LOG2 averaging,
// left-aligned signed output with a one-cycle strobe. Define ADC_FORMATEA_CLIP_EN for the sticky clip flag.
module adc_formatea_prom #(
    parameter int ADC_BITS   = 12,
    parameter int OUT_BITS   = 25,
    parameter int FRAC_SHIFT = 2,
    parameter int AVG_LOG2   = 0,
    parameter int OFFSET_BIN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [ADC_BITS-1:0] dato,
    input  logic                dato_listo,
`ifdef ADC_FORMATEA_CLIP_EN
    input  logic                clr_clip,
    output logic                clip,
`endif
    output logic [OUT_BITS-1:0] out,
    output logic                out_listo,
    output logic [AVG_LOG2:0]   cuenta
);

    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam logic [AVG_LOG2:0] N_MUESTRAS = (AVG_LOG2+1)'(1 << AVG_LOG2);
    localparam logic [AVG_LOG2:0] UNO        = (AVG_LOG2+1)'(1);
    localparam logic ACUM   = 1'b0;
    localparam logic SALIDA = 1'b1;

    generate
        if (AVG_LOG2 < 0 || AVG_LOG2 > 4 || OUT_BITS < ADC_BITS + FRAC_SHIFT) begin : g_param_invalido
            $error("adc_formatea_prom: AVG_LOG2 must be 0..4 and OUT_BITS >= ADC_BITS+FRAC_SHIFT");
        end
    endgenerate

    logic                       estado;
    logic signed [ADC_BITS-1:0] s;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    suma;
    logic signed [ACC_W-1:0]    media;
    logic signed [OUT_BITS-1:0] palabra;
    logic [AVG_LOG2:0]          base_cnt;
    logic [AVG_LOG2:0]          sig_cnt;
    logic                       acepta;
    logic                       nuevo;
    logic                       grupo_lleno;

    always_comb begin
        s = dato;
        if (OFFSET_BIN != 0) begin
            s[ADC_BITS-1] = ~dato[ADC_BITS-1];
        end
        acepta = en & dato_listo;
        // A sample arriving in SALIDA (or with nothing accumulated) opens a fresh group.
        nuevo       = (estado == SALIDA) || (cuenta == '0);
        base        = nuevo ? '0 : acc;
        base_cnt    = nuevo ? '0 : cuenta;
        suma        = base + ACC_W'(s);
        sig_cnt     = base_cnt + UNO;
        grupo_lleno = (sig_cnt == N_MUESTRAS);
        media       = suma >>> AVG_LOG2;
        palabra     = OUT_BITS'(media) <<< FRAC_SHIFT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ACUM;
            acc       <= '0;
            cuenta    <= '0;
            out       <= '0;
            out_listo <= 1'b0;
        end else begin
            out_listo <= 1'b0;
            if (acepta) begin
                acc    <= suma;
                cuenta <= sig_cnt;
                if (grupo_lleno) begin
                    out       <= palabra;
                    out_listo <= 1'b1;
                    estado    <= SALIDA;
                end else begin
                    estado <= ACUM;
                end
            end else begin
                estado <= ACUM;
                if (!en || estado == SALIDA) begin
                    cuenta <= '0;
                end
                if (!en) begin
                    acc <= '0;
                end
            end
        end
    end

`ifdef ADC_FORMATEA_CLIP_EN
    // Full scale is either rail of the raw code; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip <= 1'b0;
        end else if (acepta && (dato == '0 || &dato)) begin
            clip <= 1'b1;
        end else if (clr_clip) begin
            clip <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_adc_formatea_prom.sv
// Bench for adc_formatea_prom: three instances (AVG_LOG2 = 0,1,2) share one stimulus bus
// and are compared every cycle against a sum/count reference model.
module tb_adc_formatea_prom;

  logic        clk;
  logic        reset;
  logic        en;
  logic [11:0] dato;
  logic        dato_listo;
  logic        clr_clip;

  logic [24:0] o [3];
  logic        ol [3];
  logic [0:0]  c0;
  logic [1:0]  c1;
  logic [2:0]  c2;
  logic [31:0] c [3];
  logic        clip_o [3];

  assign c[0] = 32'(c0);
  assign c[1] = 32'(c1);
  assign c[2] = 32'(c2);

  adc_formatea_prom #(.AVG_LOG2(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .dato(dato), .dato_listo(dato_listo),
`ifdef ADC_FORMATEA_CLIP_EN
    .clr_clip(clr_clip), .clip(clip_o[0]),
`endif
    .out(o[0]), .out_listo(ol[0]), .cuenta(c0)
  );

  adc_formatea_prom #(.AVG_LOG2(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .dato(dato), .dato_listo(dato_listo),
`ifdef ADC_FORMATEA_CLIP_EN
    .clr_clip(clr_clip), .clip(clip_o[1]),
`endif
    .out(o[1]), .out_listo(ol[1]), .cuenta(c1)
  );

  adc_formatea_prom #(.AVG_LOG2(2)) u2 (
    .clk(clk), .reset(reset), .en(en), .dato(dato), .dato_listo(dato_listo),
`ifdef ADC_FORMATEA_CLIP_EN
    .clr_clip(clr_clip), .clip(clip_o[2]),
`endif
    .out(o[2]), .out_listo(ol[2]), .cuenta(c2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard counters
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: running sum and count of the open group per instance
  int          m_sum [3];
  int          m_n   [3];
  logic [24:0] m_out [3];
  logic        m_listo [3];
  int          m_cnt [3];
  logic        m_clip;

  function automatic int floordiv(input int a, input int n);
    int q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_step(input int k, input logic r, input logic e, input logic dl, input logic [11:0] d);
    int n;
    n = 1 << k;
    if (r) begin
      m_sum[k] = 0; m_n[k] = 0; m_out[k] = '0; m_listo[k] = 1'b0; m_cnt[k] = 0;
    end else begin
      m_listo[k] = 1'b0;
      if (e && dl) begin
        m_sum[k] += int'(d) - 2048;
        m_n[k]++;
        if (m_n[k] == n) begin
          m_out[k]   = 25'(floordiv(m_sum[k], n) * 4);
          m_listo[k] = 1'b1;
          m_cnt[k]   = n;
          m_sum[k]   = 0;
          m_n[k]     = 0;
        end else begin
          m_cnt[k] = m_n[k];
        end
      end else begin
        if (!e) begin
          m_sum[k] = 0;
          m_n[k]   = 0;
        end
        m_cnt[k] = m_n[k];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d out_listo", k), 32'(ol[k]), 32'(m_listo[k]));
      chk($sformatf("u%0d cuenta", k), c[k], 32'(m_cnt[k]));
      chk($sformatf("u%0d out", k), 32'(o[k]), 32'(m_out[k]));
`ifdef ADC_FORMATEA_CLIP_EN
      chk($sformatf("u%0d clip", k), 32'(clip_o[k]), 32'(m_clip));
`endif
    end
  endtask

  // driver: apply inputs at negedge, update model at posedge, compare at next negedge
  task automatic step(input logic r, input logic e, input logic dl, input logic [11:0] d,
                      input logic clr = 1'b0);
    reset = r; en = e; dato_listo = dl; dato = d; clr_clip = clr;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, e, dl, d);
    if (r) m_clip = 1'b0;
    else if (e && dl && (d == 12'h000 || d == 12'hFFF)) m_clip = 1'b1;
    else if (clr) m_clip = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic sample(input logic [11:0] d);
    step(1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; m_clip = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_sum[k] = 0; m_n[k] = 0; m_out[k] = '0; m_listo[k] = 1'b0; m_cnt[k] = 0;
    end
    reset = 1'b1; en = 1'b0; dato_listo = 1'b0; dato = '0; clr_clip = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b1, 12'hABC);
    chk("reset out", 32'(o[2]), 32'h0);
    chk("reset cuenta", c[2], 32'h0);

    // pass-through values
    sample(12'hFFF);
    chk("pt fff listo", 32'(ol[0]), 32'h1);
    chk("pt fff out", 32'(o[0]), 32'h0001FFC);
    sample(12'h000);
    chk("pt 000 out", 32'(o[0]), 32'h1FFE000);
    sample(12'h800);
    chk("pt 800 out", 32'(o[0]), 32'h0000000);
    flush();

    // averaging with gaps, cuenta progression on u2
    sample(12'h800); chk("avg cnt1", c[2], 32'd1);
    idle();          chk("avg cnt1 hold", c[2], 32'd1);
    sample(12'h801); chk("avg cnt2", c[2], 32'd2);
    sample(12'h802); chk("avg cnt3", c[2], 32'd3);
    idle();
    sample(12'h803); chk("avg cnt4", c[2], 32'd4);
    chk("avg listo", 32'(ol[2]), 32'h1);
    chk("avg out", 32'(o[2]), 32'h0000004);
    idle();          chk("avg cnt0", c[2], 32'd0);
    chk("avg listo off", 32'(ol[2]), 32'h0);
    chk("avg out hold", 32'(o[2]), 32'h0000004);

    // floor on negatives
    sample(12'h7FF); sample(12'h7FF); sample(12'h7FF); sample(12'h800);
    chk("floor out", 32'(o[2]), 32'h1FFFFFC);
    flush();

    // continuous strobes on u1
    for (int i = 0; i < 6; i++) begin
      sample(12'h802);
      chk($sformatf("cont listo %0d", i), 32'(ol[1]), 32'(i % 2));
      if (i % 2 == 1) chk($sformatf("cont out %0d", i), 32'(o[1]), 32'h0000008);
    end
    flush();

    // reset mid-group on u2
    sample(12'h900); sample(12'h900);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    chk("rst mid listo", 32'(ol[2]), 32'h0);
    chk("rst mid cnt", c[2], 32'd0);
    for (int i = 0; i < 4; i++) sample(12'h804);
    chk("rst after listo", 32'(ol[2]), 32'h1);
    chk("rst after out", 32'(o[2]), 32'h0000010);

    // enable drop mid-group on u2
    sample(12'h900); sample(12'h900);
    flush();
    chk("en mid listo", 32'(ol[2]), 32'h0);
    chk("en mid cnt", c[2], 32'd0);
    for (int i = 0; i < 4; i++) sample(12'h804);
    chk("en after listo", 32'(ol[2]), 32'h1);
    chk("en after out", 32'(o[2]), 32'h0000010);

`ifdef ADC_FORMATEA_CLIP_EN
    step(1'b1, 1'b0, 1'b0, 12'h000);
    sample(12'hFFF);                              chk("clip set", 32'(clip_o[0]), 32'h1);
    idle();                                       chk("clip held", 32'(clip_o[0]), 32'h1);
    step(1'b0, 1'b1, 1'b0, 12'h000, 1'b1);        chk("clip clr", 32'(clip_o[0]), 32'h0);
    step(1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1);        chk("clip set wins", 32'(clip_o[0]), 32'h1);
`endif

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 500; i++) begin
      logic        r, e, dl, clr;
      logic [11:0] d;
      r   = ($urandom_range(0, 59) == 0);
      e   = ($urandom_range(0, 11) != 0);
      dl  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0:       d = 12'h000;
        1:       d = 12'hFFF;
        default: d = 12'($urandom_range(0, 4095));
      endcase
      step(r, e, dl, d, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_formatea_prom.md
Name: adc_formatea_prom

Overview:
- Parametrised successor to the ADC sample formatter.
- Takes raw offset-binary ADC codes and converts them to two's complement, with proper sign extension.
- Optionally averages 2^AVG_LOG2 consecutive samples, then emits a left-aligned signed fixed-point word with a one-cycle valid strobe.
- Sits between the ADC serial controller and the filter/datapath.

Parameters:
- ADC_BITS, 12, raw ADC code width.
- OUT_BITS, 25, output word width. Must satisfy OUT_BITS >= ADC_BITS+FRAC_SHIFT.
- FRAC_SHIFT, 2, left shift applied to the converted sample. The shifted-in LSBs are zero.
- AVG_LOG2, 0, log2 of the number of samples averaged per output. Range 0..4; 0 means pass-through.
- OFFSET_BIN, 1, 1 = input is offset binary (MSB inverted on conversion); 0 = input is already two's complement.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  block enable. Low flushes accumulation.
- dato  in  ADC_BITS  raw ADC code. Sampled only when dato_listo=1.
- dato_listo  in  1  one-cycle strobe from the ADC controller: code valid.
- out  out  OUT_BITS  signed formatted sample, registered.
- out_listo  out  1  one-cycle strobe: out updated this cycle.
- cuenta  out  AVG_LOG2+1  number of samples currently accumulated, for debug.

Behaviour:
- Reset (synchronous, active-high, highest priority): out=0, out_listo=0, cuenta=0, accumulator=0, state=ACUM. Applies mid-accumulation: the partial sum is discarded and no output is produced.
- Conversion (combinational, per accepted sample): s = OFFSET_BIN ? {~dato[MSB], dato[MSB-1:0]} : dato. Interpreted as a signed ADC_BITS value.
- Accumulator: signed, ADC_BITS+AVG_LOG2 bits wide. It cannot overflow.
- Accept condition: en=1 and dato_listo=1.
- Two-state FSM:
  - ACUM: on each accept, acc <= acc+s (or acc <= s if cuenta==0) and cuenta <= cuenta+1. On the accept that makes cuenta == 2^AVG_LOG2, latch the mean and go to SALIDA.
  - SALIDA: lasts exactly one cycle. out_listo=1 and out holds the new value; cuenta cleared.
    - A sample accepted during SALIDA starts the next group: acc <= s, cuenta <= 1. No sample is ever dropped.
    - Return to ACUM.
- Mean = acc >>> AVG_LOG2 (arithmetic shift, floor toward minus infinity). No rounding.
- Output word = sign_extend(mean, OUT_BITS-FRAC_SHIFT) concatenated with FRAC_SHIFT zero bits. out holds its value between strobes.
- Latency: out_listo asserts 1 clk after the accept edge of the 2^AVG_LOG2-th sample. With AVG_LOG2=0, every accepted sample produces a strobe 1 clk later, so back-to-back dato_listo gives back-to-back out_listo.
- en low: no accept, cuenta <= 0, acc discarded. A pending SALIDA still completes its strobe. out keeps its last value.
- dato_listo while en=0: ignored.
- Out-of-range parameters (AVG_LOG2>4, or OUT_BITS too small): elaboration error via generate-time check.

Optional Feature:
- Macro: ADC_FORMATEA_CLIP_EN.
- Defined: adds input port clr_clip (1 bit) and output port clip (1 bit).
  - clip is a sticky flag, set on the cycle after any accepted raw code equals the all-zeros or all-ones code (full scale).
  - clip is cleared by clr_clip=1 or reset. If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists; no clip logic is synthesised.

Test Plan:
- Pass-through, defaults (12/25/2/AVG_LOG2=0):
  - dato=0xFFF strobe -> next clk out_listo=1, out=0x0001FFC (+8188).
  - dato=0x000 -> out=0x1FFE000 (-8192).
  - dato=0x800 -> out=0x0000000.
- Averaging, AVG_LOG2=2:
  - Codes 0x800,0x801,0x802,0x803 on 4 strobes (gaps allowed) -> one out_listo, out=0x0000004. cuenta steps 1,2,3,4, then 0.
- Floor on negatives, AVG_LOG2=2:
  - Codes 0x7FF,0x7FF,0x7FF,0x800 -> out=0x1FFFFFC (-4).
- Continuous strobes, AVG_LOG2=1:
  - dato_listo high 6 consecutive cycles with 0x802 -> out_listo pulses on 3 cycles spaced 2 apart, each out=0x0000008. No sample lost.
- Reset and enable mid-group, AVG_LOG2=2:
  - Reset after 2 accepted samples -> no out_listo, cuenta=0. The next 4 samples give a correct mean.
  - Same test with en dropped for 1 cycle instead of reset -> identical result.
- With ADC_FORMATEA_CLIP_EN defined:
  - Accept 0xFFF -> clip=1 next clk and held.
  - Pulse clr_clip -> clip=0.
  - 0xFFF arriving with clr_clip in the same cycle -> clip=1.
